// File: rtl/decode_stage_if.sv
// decode_stage_if -- handshake and bundle signals of the RV32I/M decode stage.
//   Upstream side : in_valid, in_ready, inst[31:0], in_pc[XLEN-1:0]
//   Downstream side: out_valid, out_ready, oper[6:0], rd/rs1/rs2[4:0],
//                    imm[XLEN-1:0], use_rs1, use_rs2, wr_rd, illegal,
//                    out_pc[XLEN-1:0]
// The decode stage attaches through the slave modport; the environment
// (fetch producer plus execute consumer) attaches through master.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      oper;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_rd;
    logic            illegal;
    logic [XLEN-1:0] out_pc;

    modport slave (
        input  in_valid, inst, in_pc, out_ready,
        output in_ready, out_valid, oper, rd, rs1, rs2, imm,
               use_rs1, use_rs2, wr_rd, illegal, out_pc
    );

    modport master (
        output in_valid, inst, in_pc, out_ready,
        input  in_ready, out_valid, oper, rd, rs1, rs2, imm,
               use_rs1, use_rs2, wr_rd, illegal, out_pc
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage -- RV32I (optionally M) instruction decoder with a
// valid/ready pipeline register and an optional 2-entry skid buffer.
//   clk   : clock, all registers update on the rising edge
//   rst   : synchronous active-high reset
//   flush : drops every buffered instruction and any input accepted this cycle
//   bus   : decode_stage_if.slave -- input handshake (inst, in_pc) and
//           output handshake (decoded bundle, out_pc)
// Parameters: XLEN (32/64) datapath width of imm/pc, ENABLE_M enables the
// M-extension opcodes, SKID selects the registered-ready skid buffer.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter bit SKID     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    decode_stage_if.slave        bus
);
    typedef struct packed {
        logic [6:0]      oper;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            use_rs1;
        logic            use_rs2;
        logic            wr_rd;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } bundle_t;

    // EMPTY: nothing held; ONE: output register valid; FULL: output + skid valid.
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    state_t  state_q, state_d;
    bundle_t out_q, out_d, skid_q, skid_d;
    bundle_t dec;

    logic [6:0]  opcode, funct7, oper;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    logic        has_rd, has_rs1, has_rs2;
    logic        in_hs, out_hs, out_valid;

    assign opcode = bus.inst[6:0];
    assign funct3 = bus.inst[14:12];
    assign funct7 = bus.inst[31:25];

    // Combinational decode. Every legal encoding sets a nonzero oper, so
    // oper == 0 afterwards marks the instruction illegal. opcode includes
    // inst[1:0], so non-32-bit encodings never match a case item.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        oper    = 7'd0;
        imm32   = 32'd0;
        has_rd  = 1'b0;
        has_rs1 = 1'b0;
        has_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                {has_rd, has_rs1, has_rs2} = 3'b111;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0: oper = 7'd1;
                        3'd1: oper = 7'd3;
                        3'd2: oper = 7'd4;
                        3'd3: oper = 7'd5;
                        3'd4: oper = 7'd6;
                        3'd5: oper = 7'd7;
                        3'd6: oper = 7'd9;
                        default: oper = 7'd10;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'd0)      oper = 7'd2;
                    else if (funct3 == 3'd5) oper = 7'd8;
                end else if (ENABLE_M && funct7 == 7'b0000001) begin
                    oper = 7'd42 + 7'(funct3);
                end
            end
            OPC_OP_IMM: begin
                {has_rd, has_rs1} = 2'b11;
                imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
                case (funct3)
                    3'd0: oper = 7'd11;
                    3'd2: oper = 7'd12;
                    3'd3: oper = 7'd13;
                    3'd4: oper = 7'd14;
                    3'd6: oper = 7'd15;
                    3'd7: oper = 7'd16;
                    3'd1: if (funct7 == 7'b0000000) oper = 7'd17;
                    default: begin
                        if (funct7 == 7'b0000000)      oper = 7'd18;
                        else if (funct7 == 7'b0100000) oper = 7'd19;
                    end
                endcase
            end
            OPC_LOAD: begin
                {has_rd, has_rs1} = 2'b11;
                imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
                case (funct3)
                    3'd0: oper = 7'd20;
                    3'd1: oper = 7'd21;
                    3'd2: oper = 7'd22;
                    3'd4: oper = 7'd23;
                    3'd5: oper = 7'd24;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                {has_rs1, has_rs2} = 2'b11;
                imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
                case (funct3)
                    3'd0: oper = 7'd25;
                    3'd1: oper = 7'd26;
                    3'd2: oper = 7'd27;
                    default: ;
                endcase
            end
            OPC_BRANCH: begin
                {has_rs1, has_rs2} = 2'b11;
                imm32 = {{20{bus.inst[31]}}, bus.inst[7], bus.inst[30:25],
                         bus.inst[11:8], 1'b0};
                case (funct3)
                    3'd0: oper = 7'd28;
                    3'd1: oper = 7'd29;
                    3'd4: oper = 7'd30;
                    3'd5: oper = 7'd31;
                    3'd6: oper = 7'd32;
                    3'd7: oper = 7'd33;
                    default: ;
                endcase
            end
            OPC_JAL: begin
                has_rd = 1'b1;
                imm32  = {{12{bus.inst[31]}}, bus.inst[19:12], bus.inst[20],
                          bus.inst[30:21], 1'b0};
                oper   = 7'd34;
            end
            OPC_JALR: begin
                {has_rd, has_rs1} = 2'b11;
                imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
                if (funct3 == 3'd0) oper = 7'd35;
            end
            OPC_LUI: begin
                has_rd = 1'b1;
                imm32  = {bus.inst[31:12], 12'd0};
                oper   = 7'd36;
            end
            OPC_AUIPC: begin
                has_rd = 1'b1;
                imm32  = {bus.inst[31:12], 12'd0};
                oper   = 7'd37;
            end
            OPC_MISC_MEM: begin
                // FENCE ordering bits travel in the I-immediate; no register operands.
                imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
                if (funct3 == 3'd0)      oper = 7'd38;
                else if (funct3 == 3'd1) oper = 7'd39;
            end
            OPC_SYSTEM: begin
                // Only the exact ECALL/EBREAK words are implemented.
                if (bus.inst == 32'h0000_0073)      oper = 7'd40;
                else if (bus.inst == 32'h0010_0073) oper = 7'd41;
            end
            default: ;
        endcase

        dec    = '0;
        dec.pc = bus.in_pc;
        if (oper == 7'd0) begin
            dec.illegal = 1'b1;
        end else begin
            dec.oper    = oper;
            dec.rd      = has_rd  ? bus.inst[11:7]  : 5'd0;
            dec.rs1     = has_rs1 ? bus.inst[19:15] : 5'd0;
            dec.rs2     = has_rs2 ? bus.inst[24:20] : 5'd0;
            dec.use_rs1 = has_rs1;
            dec.use_rs2 = has_rs2;
            dec.wr_rd   = has_rd && (bus.inst[11:7] != 5'd0);
            dec.imm     = XLEN'($signed(imm32));
        end
    end

    assign out_valid = (state_q != EMPTY);
    // With SKID the ready depends only on registered state; without it the
    // ready passes straight through from the consumer.
    assign bus.in_ready = ~rst & (SKID ? (state_q != FULL)
                                       : (bus.out_ready | ~out_valid));
    assign in_hs  = bus.in_valid & bus.in_ready;
    assign out_hs = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_hs) begin
                out_d   = dec;
                state_d = ONE;
            end
            ONE: begin
                if (SKID && in_hs && !out_hs) begin
                    // Consumer stalled: park the new instruction behind the output.
                    skid_d  = dec;
                    state_d = FULL;
                end else if (in_hs) begin
                    out_d = dec;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (out_hs) begin
                out_d   = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides any handshake; stale payload is harmless once invalid.
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= EMPTY;
            // NOTE: payload registers are reset too, so outputs read as zero
            // after reset instead of X.
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.oper      = out_q.oper;
    assign bus.rd        = out_q.rd;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.imm       = out_q.imm;
    assign bus.use_rs1   = out_q.use_rs1;
    assign bus.use_rs2   = out_q.use_rs2;
    assign bus.wr_rd     = out_q.wr_rd;
    assign bus.illegal   = out_q.illegal;
    assign bus.out_pc    = out_q.pc;
endmodule
